// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Two-entry pipeline stage buffer (head + skid) with valid/allowin
//            handshake, flush, and saturating backpressure stall counter.
//            in_allowin is registered from state so there is no combinational
//            path from out_allowin back to in_allowin.
// Ports    : clk, rst_n (sync, active-low), flush
//            in_valid / in_allowin / pc_inst_ibus / stage_ibus   (upstream)
//            out_valid / out_allowin / pc_inst_obus / stage_obus (downstream)
//            occupancy (0..2), stall_cnt (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int PC_INST_W = 64,
    parameter int DATA_W    = 128,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [PC_INST_W-1:0] pc_inst_ibus,
    input  logic [DATA_W-1:0]    stage_ibus,
    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic [PC_INST_W-1:0] pc_inst_obus,
    output logic [DATA_W-1:0]    stage_obus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic       c_rst_enable = 1'b0;
    localparam logic [1:0] c_st_empty   = 2'd0;
    localparam logic [1:0] c_st_one     = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_in_allowin;
    logic [PC_INST_W-1:0] r_head_pc;
    logic [DATA_W-1:0]    r_head_data;
    logic [PC_INST_W-1:0] r_skid_pc;
    logic [DATA_W-1:0]    r_skid_data;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;

    assign w_out_valid = (r_state == c_st_one) || (r_state == c_st_full);
    assign w_push      = in_valid && r_in_allowin && !flush;
    assign w_pop       = w_out_valid && out_allowin && !flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_push) w_state_nxt = c_st_one;
            c_st_one: begin
                if (w_push && !w_pop)      w_state_nxt = c_st_full;
                else if (w_pop && !w_push) w_state_nxt = c_st_empty;
            end
            c_st_full:  if (w_pop) w_state_nxt = c_st_one;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    always_ff @(posedge clk) begin
        // Reset and flush both return the stage to a clean EMPTY state;
        // reset naturally overrides everything since it is tested first.
        if (rst_n == c_rst_enable || flush) begin
            r_state      <= c_st_empty;
            r_in_allowin <= 1'b1;
            r_head_pc    <= '0;
            r_head_data  <= '0;
            r_skid_pc    <= '0;
            r_skid_data  <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_allowin <= (w_state_nxt != c_st_full);

            case (r_state)
                c_st_empty: begin
                    if (w_push) begin
                        r_head_pc   <= pc_inst_ibus;
                        r_head_data <= stage_ibus;
                    end
                end
                c_st_one: begin
                    if (w_push && w_pop) begin
                        r_head_pc   <= pc_inst_ibus;
                        r_head_data <= stage_ibus;
                    end else if (w_push) begin
                        r_skid_pc   <= pc_inst_ibus;
                        r_skid_data <= stage_ibus;
                    end else if (w_pop) begin
                        r_head_pc   <= '0;
                        r_head_data <= '0;
                    end
                end
                c_st_full: begin
                    // Push cannot occur here: in_allowin is low in FULL.
                    if (w_pop) begin
                        r_head_pc   <= r_skid_pc;
                        r_head_data <= r_skid_data;
                        r_skid_pc   <= '0;
                        r_skid_data <= '0;
                    end
                end
                default: begin
                    r_head_pc   <= '0;
                    r_head_data <= '0;
                    r_skid_pc   <= '0;
                    r_skid_data <= '0;
                end
            endcase

            // Saturating count of cycles where the head is held by downstream.
            if (w_out_valid && !out_allowin && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign in_allowin   = r_in_allowin;
    assign out_valid    = w_out_valid;
    assign pc_inst_obus = w_out_valid ? r_head_pc   : '0;
    assign stage_obus   = w_out_valid ? r_head_data : '0;
    assign occupancy    = r_state;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Purpose  : Scoreboard bench for pipe_stage_buf. Stimulus pushes expected
//            entries for beats it knows will be accepted; a negedge monitor
//            pops and compares on every downstream handshake. A second
//            instance with CNT_W=4 shares the inputs for saturation checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int PW = 64;
    localparam int DW = 128;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_allowin;
    logic [PW-1:0] pc_inst_ibus;
    logic [DW-1:0] stage_ibus;
    logic          out_valid;
    logic          out_allowin;
    logic [PW-1:0] pc_inst_obus;
    logic [DW-1:0] stage_obus;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    logic          s_in_allowin;
    logic          s_out_valid;
    logic [PW-1:0] s_pc_inst_obus;
    logic [DW-1:0] s_stage_obus;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW+DW-1:0] sb [$];

    pipe_stage_buf #(.PC_INST_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_allowin(in_allowin),
        .pc_inst_ibus(pc_inst_ibus), .stage_ibus(stage_ibus),
        .out_valid(out_valid), .out_allowin(out_allowin),
        .pc_inst_obus(pc_inst_obus), .stage_obus(stage_obus),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.PC_INST_W(PW), .DATA_W(DW), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_allowin(s_in_allowin),
        .pc_inst_ibus(pc_inst_ibus), .stage_ibus(stage_ibus),
        .out_valid(s_out_valid), .out_allowin(out_allowin),
        .pc_inst_obus(s_pc_inst_obus), .stage_obus(s_stage_obus),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream beat; acc says whether this beat must be accepted.
    task automatic beat(input logic v, input logic [PW-1:0] pc, input logic [DW-1:0] d,
                        input logic acc);
        in_valid     = v;
        pc_inst_ibus = pc;
        stage_ibus   = d;
        if (v && acc) sb.push_back({pc, d});
    endtask

    // Monitor: compare every downstream handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_allowin) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc 0x%0h data 0x%0h, required no output",
                         pc_inst_obus, stage_obus);
            end else begin
                logic [PW+DW-1:0] e;
                e = sb.pop_front();
                if ({pc_inst_obus, stage_obus} !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got pc 0x%0h data 0x%0h, required pc 0x%0h data 0x%0h",
                             pc_inst_obus, stage_obus, e[PW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_allowin = 1'b0;
        beat(1'b0, '0, '0, 1'b0);
        step(); step();
        check("rst_occ",      occupancy,    2'd0);
        check("rst_allowin",  in_allowin,   1'b1);
        check("rst_valid",    out_valid,    1'b0);
        check("rst_obus",     {pc_inst_obus, stage_obus}, '0);
        check("rst_stall",    stall_cnt,    '0);

        // Pass-through with first push right after reset release.
        rst_n = 1'b1; out_allowin = 1'b1;
        beat(1'b1, 64'h1000_0004, 128'hA5, 1'b1);
        step();
        check("pt_valid", out_valid,    1'b1);
        check("pt_pc",    pc_inst_obus, 64'h1000_0004);
        check("pt_data",  stage_obus,   128'hA5);
        check("pt_occ",   occupancy,    2'd1);
        for (int i = 1; i <= 4; i++) begin
            beat(1'b1, 64'h1000_0004 + 64'(4*i), 128'hA5 + 128'(i), 1'b1);
            step();
            check("stream_occ", occupancy, 2'd1);
            check("stream_allowin", in_allowin, 1'b1);
        end
        beat(1'b0, '0, '0, 1'b0);
        step();
        check("pt_drain_occ", occupancy, 2'd0);
        check("pt_stall",     stall_cnt, '0);

        // Backpressure: fill, third beat refused, drain in order.
        out_allowin = 1'b0;
        beat(1'b1, 64'h11, 128'h11, 1'b1);
        step();
        check("bp_occ1",   occupancy, 2'd1);
        check("bp_stall0", stall_cnt, 16'd0);
        beat(1'b1, 64'h22, 128'h22, 1'b1);
        step();
        check("bp_occ2",     occupancy,  2'd2);
        check("bp_allowin0", in_allowin, 1'b0);
        check("bp_stall1",   stall_cnt,  16'd1);
        beat(1'b1, 64'h33, 128'h33, 1'b0);
        step();
        check("bp_occ_hold", occupancy, 2'd2);
        check("bp_head",     stage_obus, 128'h11);
        check("bp_stall2",   stall_cnt, 16'd2);
        step();
        check("bp_stall3",   stall_cnt, 16'd3);
        beat(1'b0, '0, '0, 1'b0);
        out_allowin = 1'b1;
        step();
        check("bp_drain_occ1", occupancy, 2'd1);
        check("bp_drain_head", stage_obus, 128'h22);
        step();
        check("bp_drain_occ0", occupancy, 2'd0);
        check("bp_stall_kept", stall_cnt, 16'd3);

        // Simultaneous push and pop in ONE.
        out_allowin = 1'b0;
        beat(1'b1, 64'h11, 128'h11, 1'b1);
        step();
        out_allowin = 1'b1;
        beat(1'b1, 64'h22, 128'h22, 1'b1);
        step();
        check("pp_head", stage_obus, 128'h22);
        check("pp_occ",  occupancy,  2'd1);
        beat(1'b0, '0, '0, 1'b0);
        step();

        // Flush while FULL with a concurrent beat.
        out_allowin = 1'b0;
        beat(1'b1, 64'hA1, 128'hA1, 1'b1);
        step();
        beat(1'b1, 64'hA2, 128'hA2, 1'b1);
        step();
        check("fl_pre_occ", occupancy, 2'd2);
        check("fl_pre_stall", stall_cnt, 16'd4);
        sb.delete();
        flush = 1'b1;
        beat(1'b1, 64'hA3, 128'hA3, 1'b0);
        step();
        check("fl_occ",     occupancy,  2'd0);
        check("fl_valid",   out_valid,  1'b0);
        check("fl_obus",    {pc_inst_obus, stage_obus}, '0);
        check("fl_stall",   stall_cnt,  16'd0);
        check("fl_allowin", in_allowin, 1'b1);
        flush = 1'b0; out_allowin = 1'b1;
        beat(1'b0, '0, '0, 1'b0);
        step();
        check("fl_no_beat", out_valid, 1'b0);

        // Saturation on the CNT_W=4 instance.
        out_allowin = 1'b0;
        beat(1'b1, 64'hB1, 128'hB1, 1'b1);
        step();
        beat(1'b0, '0, '0, 1'b0);
        repeat (20) step();
        check("sat_s15",  s_stall_cnt, 4'd15);
        check("sat_d20",  stall_cnt,   16'd20);
        repeat (5) step();
        check("sat_s15_hold", s_stall_cnt, 4'd15);
        check("sat_d25",      stall_cnt,   16'd25);
        out_allowin = 1'b1;
        step();
        check("sat_drain_occ", occupancy, 2'd0);

        // Reset while FULL, then push right after release.
        out_allowin = 1'b0;
        beat(1'b1, 64'hC1, 128'hC1, 1'b1);
        step();
        beat(1'b1, 64'hC2, 128'hC2, 1'b1);
        step();
        check("rs_pre_occ", occupancy, 2'd2);
        sb.delete();
        rst_n = 1'b0;
        beat(1'b1, 64'hC3, 128'hC3, 1'b0);
        step();
        check("rs_occ",     occupancy,  2'd0);
        check("rs_allowin", in_allowin, 1'b1);
        check("rs_valid",   out_valid,  1'b0);
        check("rs_obus",    {pc_inst_obus, stage_obus}, '0);
        check("rs_stall",   stall_cnt,  16'd0);
        rst_n = 1'b1; out_allowin = 1'b1;
        beat(1'b1, 64'hD1, 128'hD1, 1'b1);
        step();
        check("rs_push_valid", out_valid,  1'b1);
        check("rs_push_data",  stage_obus, 128'hD1);
        beat(1'b0, '0, '0, 1'b0);
        step(); step();
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
